// File: rtl/frame_sync_pkg.sv
// frame_sync_pkg
//   Shared definitions for the parametrised frame synchroniser.
//   - ST_* : 2-bit state encoding, also driven out on the State port.
//   - popcount : number of set bits in a 32-bit vector (used to count
//     mismatched bits between the received window and the sync word).
package frame_sync_pkg;

  localparam logic [1:0] ST_SEARCH = 2'b00;
  localparam logic [1:0] ST_VERIFY = 2'b01;
  localparam logic [1:0] ST_LOCK   = 2'b10;
  localparam logic [1:0] ST_CHECK  = 2'b11;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/frame_sync_param_sync_correlator.sv
// sync_correlator
//   Sliding-window correlator for the serial sync word. The window is the
//   previous SYNC_W-1 received bits plus the bit currently on data_in, so
//   hit is combinational on the cycle the last sync bit arrives.
//   Ports:
//     clk      in  clock, rising edge
//     rst      in  synchronous active-high reset
//     data_in  in  serial bit, one per clock
//     hit      out window differs from SYNC_WORD in at most MAX_ERR bits
//                  (held low until a full window has been received)
module sync_correlator
  import frame_sync_pkg::*;
#(
  parameter int                SYNC_W    = 7,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 7'b1110010,
  parameter int                MAX_ERR   = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic hit
);

  localparam int               FILL_W    = $clog2(SYNC_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W - 1);
  localparam logic [5:0]       ERR_LIMIT = 6'(MAX_ERR);

  // Only SYNC_W-1 history bits are needed: the newest bit comes from data_in.
  logic [SYNC_W-2:0] sr_q, sr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [SYNC_W-1:0] cand;
  logic [5:0]        err_cnt;

  always_comb begin
    cand    = {sr_q, data_in};
    sr_d    = cand[SYNC_W-2:0];
    // Fill counter saturates once SYNC_W-1 bits are stored; from then on
    // every window is made of real received bits.
    fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    err_cnt = popcount(32'(cand ^ SYNC_WORD));
    hit     = (fill_q == FILL_FULL) && (err_cnt <= ERR_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      fill_q <= '0;
    end else begin
      sr_q   <= sr_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/frame_sync_param.sv
// frame_sync_param
//   Serial frame synchroniser. A frame is FRAME_LEN bits: payload at bit
//   positions 0..FRAME_LEN-SYNC_W-1 followed by the sync word, whose last
//   bit sits at position FRAME_LEN-1 (the expected position). Lock needs
//   CONFIRM_N consecutive hits at the expected position; lock is dropped
//   after LOSE_M consecutive misses there.
//   Ports:
//     Clock       in   sole clock, rising edge
//     Reset       in   synchronous active-high reset
//     DataIn      in   serial stream, one bit per clock
//     DataOut     out  DataIn delayed by one clock
//     DataOutEn   out  DataOut carries a payload bit of a locked frame
//     FrameStart  out  marks the first payload bit of each frame
//     State       out  00 SEARCH, 01 VERIFY, 10 LOCK, 11 CHECK
//     LockLost    out  one-clock pulse when LOCK/CHECK falls to SEARCH
module frame_sync_param
  import frame_sync_pkg::*;
#(
  parameter int                SYNC_W    = 7,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 7'b1110010,
  parameter int                FRAME_LEN = 256,
  parameter int                CONFIRM_N = 2,
  parameter int                LOSE_M    = 3,
  parameter int                MAX_ERR   = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       DataIn,
  output logic       DataOut,
  output logic       DataOutEn,
  output logic       FrameStart,
  output logic [1:0] State,
  output logic       LockLost
);

  localparam int BC_W = $clog2(FRAME_LEN);
  localparam int HC_W = $clog2(CONFIRM_N + 1);
  localparam int MC_W = $clog2(LOSE_M + 1);

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(FRAME_LEN - 1);
  localparam logic [BC_W-1:0] PAY_LEN  = BC_W'(FRAME_LEN - SYNC_W);
  localparam logic [HC_W-1:0] HIT_ONE  = HC_W'(1);
  localparam logic [HC_W-1:0] HIT_TGT  = HC_W'(CONFIRM_N);
  localparam logic [MC_W-1:0] MISS_ONE = MC_W'(1);
  localparam logic [MC_W-1:0] MISS_TGT = MC_W'(LOSE_M);

  logic            hit;
  logic            at_exp;
  logic            locked;

  logic [1:0]      state_q,     state_d;
  logic [BC_W-1:0] bitcnt_q,    bitcnt_d;
  logic [HC_W-1:0] hitcnt_q,    hitcnt_d;
  logic [MC_W-1:0] misscnt_q,   misscnt_d;
  logic            data_out_q,  data_out_d;
  logic            out_en_q,    out_en_d;
  logic            frm_start_q, frm_start_d;
  logic            lock_lost_q, lock_lost_d;

  sync_correlator #(
    .SYNC_W    (SYNC_W),
    .SYNC_WORD (SYNC_WORD),
    .MAX_ERR   (MAX_ERR)
  ) u_corr (
    .clk     (Clock),
    .rst     (Reset),
    .data_in (DataIn),
    .hit     (hit)
  );

  always_comb begin
    at_exp      = (bitcnt_q == BIT_LAST);
    state_d     = state_q;
    bitcnt_d    = at_exp ? '0 : bitcnt_q + 1'b1;
    hitcnt_d    = hitcnt_q;
    misscnt_d   = misscnt_q;
    lock_lost_d = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (hit) begin
          // The bit after the sync word is payload position 0.
          bitcnt_d  = '0;
          hitcnt_d  = HIT_ONE;
          misscnt_d = '0;
          state_d   = (CONFIRM_N == 1) ? ST_LOCK : ST_VERIFY;
        end
      end

      ST_VERIFY: begin
        if (at_exp) begin
          if (hit) begin
            if (hitcnt_q + 1'b1 == HIT_TGT) begin
              state_d  = ST_LOCK;
              hitcnt_d = '0;
            end else begin
              hitcnt_d = hitcnt_q + 1'b1;
            end
          end else begin
            state_d  = ST_SEARCH;
            hitcnt_d = '0;
          end
        end else if (hit && (hitcnt_q == HIT_ONE) && (bitcnt_q == '0)) begin
          // A hit directly after the entering hit (overlapping pattern)
          // re-anchors the frame on the later hit.
          bitcnt_d = '0;
        end
      end

      ST_LOCK: begin
        if (at_exp && !hit) begin
          if (LOSE_M == 1) begin
            state_d     = ST_SEARCH;
            lock_lost_d = 1'b1;
            misscnt_d   = '0;
          end else begin
            state_d   = ST_CHECK;
            misscnt_d = MISS_ONE;
          end
        end
      end

      ST_CHECK: begin
        if (at_exp) begin
          if (hit) begin
            state_d   = ST_LOCK;
            misscnt_d = '0;
          end else if (misscnt_q + 1'b1 == MISS_TGT) begin
            state_d     = ST_SEARCH;
            lock_lost_d = 1'b1;
            misscnt_d   = '0;
          end else begin
            misscnt_d = misscnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d   = ST_SEARCH;
        hitcnt_d  = '0;
        misscnt_d = '0;
      end
    endcase

    // Output qualifiers look at the state/position of the bit now on DataIn,
    // so they line up with that bit once it is registered onto DataOut.
    locked      = (state_q == ST_LOCK) || (state_q == ST_CHECK);
    data_out_d  = DataIn;
    out_en_d    = locked && (bitcnt_q < PAY_LEN);
    frm_start_d = locked && (bitcnt_q == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_SEARCH;
      bitcnt_q    <= '0;
      hitcnt_q    <= '0;
      misscnt_q   <= '0;
      data_out_q  <= 1'b0;
      out_en_q    <= 1'b0;
      frm_start_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      hitcnt_q    <= hitcnt_d;
      misscnt_q   <= misscnt_d;
      data_out_q  <= data_out_d;
      out_en_q    <= out_en_d;
      frm_start_q <= frm_start_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign DataOut    = data_out_q;
  assign DataOutEn  = out_en_q;
  assign FrameStart = frm_start_q;
  assign State      = state_q;
  assign LockLost   = lock_lost_q;

endmodule

// File: doc/frame_sync_param.md
# frame_sync_param

Parametrised serial frame synchroniser. It correlates a 1-bit input stream against a configurable sync word, optionally tolerating bit errors. Lock requires N consecutive on-position hits, and lock is lost only after M consecutive misses. While locked, it emits the payload bits with a qualifier and a frame-start strobe. It sits directly downstream of the serial frame source (FrameTrans-class generator) and replaces the fixed-format frame-sync FSM.

## Interface
- SYNC_W, 7, sync word width in bits (2..32)
- SYNC_WORD, 7'b1110010, sync pattern; the MSB arrives first on DataIn
- FRAME_LEN, 256, total bits per frame including the sync word; must be > SYNC_W
- CONFIRM_N, 2, consecutive on-position hits required to enter lock (≥1)
- LOSE_M, 3, consecutive on-position misses required to drop lock (≥1)
- MAX_ERR, 0, maximum mismatched bits still counted as a hit (< SYNC_W)

Ports:
- Clock  in  1  sole clock, rising edge
- Reset  in  1  synchronous, active-high
- DataIn  in  1  serial stream, one bit per Clock
- DataOut  out  1  payload bit (registered)
- DataOutEn  out  1  DataOut valid
- FrameStart  out  1  1-cycle pulse coincident with the first payload bit of each frame
- State  out  2  00 SEARCH, 01 VERIFY, 10 LOCK, 11 CHECK
- LockLost  out  1  1-cycle pulse on any transition from LOCK/CHECK to SEARCH

## Operation
- Correlator: `cand = {sr[SYNC_W-2:0], DataIn}`; `sr <= cand` every cycle.
  - hit = popcount(cand ^ SYNC_WORD) ≤ MAX_ERR.
  - hit is forced to 0 until SYNC_W bits have been received since reset (fill counter saturates at SYNC_W-1).
- Bit counter `bitcnt`, range 0..FRAME_LEN-1:
  - Wraps FRAME_LEN-1 → 0.
  - Forced to 0 on the cycle after a SEARCH hit.
  - The "expected position" is bitcnt == FRAME_LEN-1.
  - Payload bits occupy bitcnt 0..FRAME_LEN-SYNC_W-1.
- SEARCH: a hit takes the FSM to VERIFY, with hitcnt=1 and bitcnt←0. If CONFIRM_N==1, a hit goes straight to LOCK.
- VERIFY: only the expected position is evaluated; hits elsewhere are ignored.
  - Hit: hitcnt+1. On reaching CONFIRM_N, go to LOCK.
  - Miss: go to SEARCH, which re-arms on the very next hit.
- LOCK: at the expected position, a hit stays in LOCK. A miss goes to CHECK with misscnt=1; if LOSE_M==1 it goes to SEARCH instead.
- CHECK: at the expected position, a hit returns to LOCK with misscnt=0. A miss increments misscnt; when it equals LOSE_M, go to SEARCH.
- CHECK continues to deliver payload; the frame timing is held as-is.
- Outputs, all registered:
  - DataOut ← DataIn every cycle.
  - DataOutEn ← (State ∈ {LOCK, CHECK}) && bitcnt < FRAME_LEN-SYNC_W.
  - FrameStart ← the same qualifier && bitcnt==0.
- Counter widths: bitcnt is $clog2(FRAME_LEN); hitcnt and misscnt are sized to CONFIRM_N and LOSE_M; none of them overflow.

## Timing
- Reset values: State=00, DataOut=0, DataOutEn=0, FrameStart=0, LockLost=0. sr, bitcnt, hitcnt, misscnt and the fill counter are all 0.
- Reset asserted mid-frame: all outputs reach their reset values at the next edge, and the fill guard restarts.
- Latency: DataIn → DataOut is 1 cycle.
- Lock timing: the hit on the sync-end bit of frame CONFIRM_N gives State=LOCK one edge later. The payload bit 0 of the following frame appears with DataOutEn=1 and FrameStart=1 one cycle after that bit is on DataIn.
- Loss timing: on the LOSE_M-th miss, State=SEARCH and LockLost=1 for exactly one cycle. DataOutEn=0 from the same edge.
- Simultaneous events: a hit at the expected position and Reset in the same cycle → Reset wins.
- In SEARCH, a hit on consecutive cycles (overlapping pattern) restarts bitcnt each time while the FSM remains in VERIFY-entry semantics; the latest hit wins.

## Structure
- Shared package frame_sync_pkg contains:
  - State encoding localparams ST_SEARCH, ST_VERIFY, ST_LOCK, ST_CHECK.
  - A popcount function.
- Sub-module sync_correlator (parameters SYNC_W, SYNC_WORD, MAX_ERR) contains the shift register, fill guard and hit output.
- The top level contains the FSM, counters and output registers.

## Test plan
All scenarios use SYNC_W=7, SYNC_WORD=7'b1110010, FRAME_LEN=32, CONFIRM_N=2, LOSE_M=3 and MAX_ERR=0 unless stated otherwise.
- Clean frames with random 25-bit payloads:
  - State goes 00→01 after the first sync and 01→10 after the second.
  - Thereafter DataOutEn is high for 25 cycles per 32, with one FrameStart per frame.
  - DataOut equals the payload delayed by 1.
- Sync pattern embedded in the payload during VERIFY: it is ignored; State stays 01 and bitcnt alignment is unchanged.
- In LOCK, one corrupted sync then a good one: State goes 10→11→10, and DataOutEn is uninterrupted.
- Three consecutive corrupted syncs: State goes 10→11→11→00 at the third expected position, with a 1-cycle LockLost and DataOutEn=0 from that edge.
- MAX_ERR=1:
  - A sync with 1 flipped bit counts as a hit and lock is held.
  - A sync with 2 flipped bits counts as a miss and State goes to 11.
- SYNC_WORD=7'b0000000 with DataIn held at 0 after Reset: no hit on cycles 1–6; VERIFY is entered on cycle 7.
- Reset pulsed mid-payload while locked: all outputs take their reset values at the next edge.
